fifo_status_gen: RTL and testbench

Write-side and status controller for the synchronous FIFO. It owns the write address and the occupancy count. It produces the empty/full flags consumed by rd_addr_gen and the write port, and mirrors rd_addr_gen's read-acceptance rule so both sides stay in lockstep on a shared RAM of depth 2^FIFO_PTR_WIDE.

---
 rtl/fifo_status_gen.sv | 84 ++++++++
 tb/tb_fifo_status_gen.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_status_gen.sv
// Write-side and status controller for a synchronous FIFO of depth 2**FIFO_PTR_WIDE.
// It owns the RAM write address and the occupancy count, and it produces the
// empty/full/almost flags and the overflow/underflow pulses. Its read-acceptance
// rule matches rd_addr_gen, so both address generators stay in lockstep.
//
// Ports:
//   clk          system clock; all state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   wr_en        write request from the producer
//   rd_en        read request from the consumer (the same signal drives rd_addr_gen)
//   wr_addr      RAM address that the write accepted in the current cycle uses
//   fifo_cnt     occupancy, 0..DEPTH
//   empty        fifo_cnt == 0
//   full         fifo_cnt == DEPTH
//   almost_empty fifo_cnt <= AE_LEVEL
//   almost_full  fifo_cnt >= AF_LEVEL
//   overflow     one-cycle pulse after a write attempted while full
//   underflow    one-cycle pulse after a read attempted while empty
module fifo_status_gen #(
    parameter int unsigned FIFO_PTR_WIDE = 3,
    parameter int unsigned AF_LEVEL      = 6,
    parameter int unsigned AE_LEVEL      = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic                     rd_en,
    output logic [FIFO_PTR_WIDE-1:0] wr_addr,
    output logic [FIFO_PTR_WIDE:0]   fifo_cnt,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_empty,
    output logic                     almost_full,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned DEPTH = 1 << FIFO_PTR_WIDE;
    localparam int unsigned CW    = FIFO_PTR_WIDE + 1;

    logic          wr_acc;
    logic          rd_acc;
    logic [CW-1:0] cnt_nxt;

    // Acceptance and next occupancy, evaluated against the current registered flags
    always_comb begin
        wr_acc  = wr_en & ~full;
        rd_acc  = rd_en & ~empty;
        cnt_nxt = fifo_cnt;
        if (wr_acc && !rd_acc) begin
            cnt_nxt = fifo_cnt + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            cnt_nxt = fifo_cnt - CW'(1);
        end
    end

    // The flags are decoded from cnt_nxt and registered, so each flag always matches
    // the registered fifo_cnt and changes in the same cycle as the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr      <= '0;
            fifo_cnt     <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            // The write address wraps from DEPTH-1 to 0 through natural overflow.
            if (wr_acc) begin
                wr_addr <= wr_addr + FIFO_PTR_WIDE'(1);
            end
            fifo_cnt     <= cnt_nxt;
            empty        <= (cnt_nxt == '0);
            full         <= (cnt_nxt == CW'(DEPTH));
            almost_empty <= (cnt_nxt <= CW'(AE_LEVEL));
            almost_full  <= (cnt_nxt >= CW'(AF_LEVEL));
            overflow     <= wr_en & full;
            underflow    <= rd_en & empty;
        end
    end

endmodule

// File: tb/tb_fifo_status_gen.sv
module tb_fifo_status_gen;

    localparam int unsigned PW    = 3;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AF    = 6;
    localparam int unsigned AE    = 1;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic          rd_en;
    logic [PW-1:0] wr_addr;
    logic [PW:0]   fifo_cnt;
    logic          empty, full, almost_empty, almost_full, overflow, underflow;

    int checks = 0;
    int errors = 0;

    // Reference model: an ideal FIFO queue plus a shadow RAM and a read pointer
    int unsigned q[$];
    int unsigned mem [DEPTH];
    int          rd_ptr;
    int          wr_total;

    fifo_status_gen #(.FIFO_PTR_WIDE(PW), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en),
        .wr_addr(wr_addr), .fifo_cnt(fifo_cnt), .empty(empty), .full(full),
        .almost_empty(almost_empty), .almost_full(almost_full),
        .overflow(overflow), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic wr;
        logic rd;
        int   cnt;
        int   addr;
        logic ov;
        logic un;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic w, logic r, int c, int a, logic o, logic u);
        vec_t v;
        v.wr = w; v.rd = r; v.cnt = c; v.addr = a; v.ov = o; v.un = u;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Check the count and the flags that follow from it by their definitions.
    task automatic chk_cnt_flags(input string tag, input int c);
        chk({tag, " fifo_cnt"}, int'(fifo_cnt), c);
        chk({tag, " empty"}, int'(empty), int'(c == 0));
        chk({tag, " full"}, int'(full), int'(c == DEPTH));
        chk({tag, " almost_empty"}, int'(almost_empty), int'(c <= AE));
        chk({tag, " almost_full"}, int'(almost_full), int'(c >= AF));
    endtask

    // Reset asserted mid-cycle; outputs are checked before any clock edge.
    task automatic do_reset(input string tag);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        #1;
        chk_cnt_flags(tag, 0);
        chk({tag, " wr_addr"}, int'(wr_addr), 0);
        chk({tag, " overflow"}, int'(overflow), 0);
        chk({tag, " underflow"}, int'(underflow), 0);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        rd_ptr   = 0;
        wr_total = 0;
    endtask

    // One cycle against the reference model, with a data and lockstep scoreboard.
    task automatic cyc(input logic w, input logic r, input string tag);
        int          sz;
        bit          wa, ra;
        int unsigned d, exp_d;
        sz = q.size();
        wa = w && (sz < DEPTH);
        ra = r && (sz > 0);
        @(negedge clk);
        wr_en = w;
        rd_en = r;
        if (ra) begin
            exp_d = q.pop_front();
            chk({tag, " read data"}, int'(mem[rd_ptr]), int'(exp_d));
            rd_ptr = (rd_ptr + 1) % DEPTH;
        end
        if (wa) begin
            d = $urandom;
            mem[wr_addr] = d;
            q.push_back(d);
            wr_total++;
        end
        @(posedge clk);
        #1;
        chk_cnt_flags(tag, q.size());
        chk({tag, " wr_addr"}, int'(wr_addr), wr_total % DEPTH);
        chk({tag, " lockstep"}, (int'(wr_addr) - rd_ptr + DEPTH) % DEPTH, q.size() % DEPTH);
        chk({tag, " overflow"}, int'(overflow), int'(w && sz == DEPTH));
        chk({tag, " underflow"}, int'(underflow), int'(r && sz == 0));
    endtask

    initial begin
        rst_n = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        rd_ptr   = 0;
        wr_total = 0;
        #12;
        chk_cnt_flags("por", 0);
        chk("por wr_addr", int'(wr_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Three writes, then an asynchronous reset in the middle of a cycle
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, "pre");
        chk("pre wr_addr3", int'(wr_addr), 3);
        @(negedge clk);
        wr_en = 1'b1;
        do_reset("async_rst");

        // Directed table: fill, overflow, drain, underflow, simultaneous at boundaries
        for (int i = 1; i <= 7; i++) tbl.push_back(mk(1, 0, i, i, 0, 0));
        tbl.push_back(mk(1, 0, 8, 0, 0, 0));
        tbl.push_back(mk(1, 0, 8, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8, 0, 0, 0));
        tbl.push_back(mk(1, 1, 7, 0, 1, 0));
        tbl.push_back(mk(1, 0, 8, 1, 0, 0));
        for (int i = 7; i >= 0; i--) tbl.push_back(mk(0, 1, i, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 1));
        tbl.push_back(mk(1, 1, 1, 2, 0, 1));
        tbl.push_back(mk(1, 0, 2, 3, 0, 0));
        tbl.push_back(mk(1, 0, 3, 4, 0, 0));
        tbl.push_back(mk(1, 0, 4, 5, 0, 0));
        tbl.push_back(mk(1, 1, 4, 6, 0, 0));
        tbl.push_back(mk(0, 0, 4, 6, 0, 0));

        foreach (tbl[i]) begin
            @(negedge clk);
            wr_en = tbl[i].wr;
            rd_en = tbl[i].rd;
            @(posedge clk);
            #1;
            chk_cnt_flags($sformatf("tbl%0d", i), tbl[i].cnt);
            chk($sformatf("tbl%0d wr_addr", i), int'(wr_addr), tbl[i].addr);
            chk($sformatf("tbl%0d overflow", i), int'(overflow), int'(tbl[i].ov));
            chk($sformatf("tbl%0d underflow", i), int'(underflow), int'(tbl[i].un));
        end

        // Random lockstep run against the queue model
        do_reset("rst_rand");
        for (int i = 0; i < 1000; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
        end

        // Wrap stress: occupancy held in 2..5 while the write address wraps repeatedly
        do_reset("rst_wrap");
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, "wrap_pre");
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'(q.size() >= 4), "wrap");
            checks++;
            if (fifo_cnt < 2 || fifo_cnt > 5 || overflow || underflow) begin
                errors++;
                $display("FAIL wrap range: cnt=%0d ov=%0b un=%0b required cnt 2..5, no pulses",
                         fifo_cnt, overflow, underflow);
            end
        end
        chk("wrap count of writes", wr_total, 23);

        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
